// File: rtl/if_mem_ctrl.sv
// if_mem_ctrl: instruction-fetch responder on the memory-controller side.
//
// Accepts a fetch request (if_i, pc_i) and reads four sequential bytes from a byte-wide RAM
// whose read data returns one cycle after the address cycle. The bytes are assembled
// little-endian into a 32-bit word, which is delivered with a one-cycle inst_valid_o pulse.
// Back-to-back fetches are accepted in the DONE cycle. A flush aborts an in-flight fetch.
// A data-path stall only blocks acceptance.
//
// Optional feature (macro IF_LASTHIT_EN): a one-entry last-hit buffer. A repeat fetch of the
// last delivered pc skips the RAM and completes in one cycle. A data store invalidates it.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous reset, active-low
//   if_i         fetch request
//   pc_i         instruction byte address, valid with if_i
//   if_busy_o    a request presented this cycle is not accepted
//   flush_i      jump/redirect, aborts the in-flight fetch and gates inst_valid_o
//   mem_stall_i  data path owns the RAM, blocks acceptance
//   mem_wr_i     data store occurred (last-hit invalidate, configured builds only)
//   mem_rd_o     RAM read strobe
//   mem_a_o      RAM byte address
//   mem_din_i    RAM read data, one cycle after the address cycle
//   inst_valid_o one-cycle pulse, inst_o holds a new instruction
//   inst_o       fetched instruction
//   inst_pc_o    address of the instruction in inst_o

module if_mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_i,
    input  logic [31:0] pc_i,
    output logic        if_busy_o,
    input  logic        flush_i,
    input  logic        mem_stall_i,
    input  logic        mem_wr_i,
    output logic        mem_rd_o,
    output logic [31:0] mem_a_o,
    input  logic [7:0]  mem_din_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o
);

    typedef enum logic [2:0] {
        StIdle,
        StB0,
        StB1,
        StB2,
        StB3,
        StB4,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [23:0] byte_q, byte_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;

    logic        in_fetch;
    logic        rd_strobe;
    logic [1:0]  rd_offset;
    logic        accept;
    logic        fill;
    logic        hit;
    logic [31:0] hit_word;

    // State decode for the RAM side.
    always_comb begin
        in_fetch  = 1'b0;
        rd_strobe = 1'b0;
        rd_offset = 2'd0;
        unique case (state_q)
            StB0: begin
                in_fetch  = 1'b1;
                rd_strobe = 1'b1;
                rd_offset = 2'd0;
            end
            StB1: begin
                in_fetch  = 1'b1;
                rd_strobe = 1'b1;
                rd_offset = 2'd1;
            end
            StB2: begin
                in_fetch  = 1'b1;
                rd_strobe = 1'b1;
                rd_offset = 2'd2;
            end
            StB3: begin
                in_fetch  = 1'b1;
                rd_strobe = 1'b1;
                rd_offset = 2'd3;
            end
            StB4: begin
                in_fetch = 1'b1;
            end
            default: ;
        endcase
    end

    // Only IDLE and DONE can accept, so the stall term matters only there.
    assign if_busy_o    = in_fetch | mem_stall_i;
    assign accept       = if_i & ~if_busy_o;
    assign mem_rd_o     = rd_strobe;
    assign mem_a_o      = rd_strobe ? (pc_q + {30'd0, rd_offset}) : 32'd0;
    assign inst_valid_o = (state_q == StDone) & ~flush_i;
    assign inst_o       = inst_q;
    assign inst_pc_o    = inst_pc_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        byte_d    = byte_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        fill      = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                // An accepted request wins over flush: it carries the jump target.
                if (accept) begin
                    pc_d = pc_i;
                    if (hit) begin
                        state_d   = StDone;
                        inst_d    = hit_word;
                        inst_pc_d = pc_i;
                    end else begin
                        state_d = StB0;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StB0: begin
                state_d = flush_i ? StIdle : StB1;
            end
            StB1: begin
                byte_d[7:0] = mem_din_i;
                state_d     = flush_i ? StIdle : StB2;
            end
            StB2: begin
                byte_d[15:8] = mem_din_i;
                state_d      = flush_i ? StIdle : StB3;
            end
            StB3: begin
                byte_d[23:16] = mem_din_i;
                state_d       = flush_i ? StIdle : StB4;
            end
            StB4: begin
                if (flush_i) begin
                    state_d = StIdle;
                end else begin
                    inst_d    = {mem_din_i, byte_q};
                    inst_pc_d = pc_q;
                    fill      = 1'b1;
                    state_d   = StDone;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            pc_q      <= 32'd0;
            byte_q    <= 24'd0;
            inst_q    <= 32'd0;
            inst_pc_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            byte_q    <= byte_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
        end
    end

`ifdef IF_LASTHIT_EN
    logic        hit_valid_q;
    logic [31:0] hit_tag_q;
    logic [31:0] hit_word_q;

    // A store in the same cycle as a fill still invalidates: the fetched bytes may be stale.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_valid_q <= 1'b0;
            hit_tag_q   <= 32'd0;
            hit_word_q  <= 32'd0;
        end else begin
            if (fill) begin
                hit_tag_q  <= pc_q;
                hit_word_q <= {mem_din_i, byte_q};
            end
            if (mem_wr_i) begin
                hit_valid_q <= 1'b0;
            end else if (fill) begin
                hit_valid_q <= 1'b1;
            end
        end
    end

    assign hit      = hit_valid_q & ~mem_wr_i & (pc_i == hit_tag_q);
    assign hit_word = hit_word_q;
`else
    logic unused_cfg;

    assign hit        = 1'b0;
    assign hit_word   = 32'd0;
    assign unused_cfg = mem_wr_i | fill;
`endif

endmodule

// File: tb/tb_if_mem_ctrl.sv
module tb_if_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        if_i;
    logic [31:0] pc_i;
    logic        if_busy_o;
    logic        flush_i;
    logic        mem_stall_i;
    logic        mem_wr_i;
    logic        mem_rd_o;
    logic [31:0] mem_a_o;
    logic [7:0]  mem_din_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;

    if_mem_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .if_i         (if_i),
        .pc_i         (pc_i),
        .if_busy_o    (if_busy_o),
        .flush_i      (flush_i),
        .mem_stall_i  (mem_stall_i),
        .mem_wr_i     (mem_wr_i),
        .mem_rd_o     (mem_rd_o),
        .mem_a_o      (mem_a_o),
        .mem_din_i    (mem_din_i),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        int          due;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_tot  = 0;
    int   cyc    = 0;

    // Reference model: a fetch in flight ages 0..4 (0..3 are read cycles), then delivers.
    bit          m_fl;
    int          m_age;
    logic [31:0] m_pc;
    bit          m_done;
    bit          lh_valid;
    logic [31:0] lh_tag;

    function automatic logic [7:0] ram_byte(input logic [31:0] a);
        logic [31:0] h;
        case (a)
            32'h100: return 8'h93;
            32'h101: return 8'h00;
            32'h102: return 8'h10;
            32'h103: return 8'h00;
            default: ;
        endcase
        h = a * 32'h9E3779B1;
        h = h ^ (h >> 15);
        return h[7:0];
    endfunction

    function automatic logic [31:0] fetch_word(input logic [31:0] a);
        return {ram_byte(a + 32'd3), ram_byte(a + 32'd2), ram_byte(a + 32'd1), ram_byte(a)};
    endfunction

    // Byte-wide RAM with one-cycle read latency; garbage when not reading.
    always @(posedge clk) begin
        if (mem_rd_o) mem_din_i <= ram_byte(mem_a_o);
        else          mem_din_i <= 8'($urandom);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tot++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
    endtask

    task automatic model_clear();
        m_fl     = 0;
        m_age    = 0;
        m_pc     = 32'd0;
        m_done   = 0;
        lh_valid = 0;
        lh_tag   = 32'd0;
        q.delete();
    endtask

    // Advance the model over one rising edge using the inputs the DUT saw at that edge.
    task automatic model_edge();
        bit   acc;
        bit   is_hit;
        exp_t e;
        acc    = if_i && !(m_fl || mem_stall_i);
        is_hit = 0;
`ifdef IF_LASTHIT_EN
        is_hit = lh_valid && (lh_tag == pc_i) && !mem_wr_i;
`endif
        if (m_fl) begin
            m_done = 0;
            if (flush_i) begin
                m_fl = 0;
                if (q.size() > 0) void'(q.pop_back());
            end else if (m_age == 4) begin
                m_fl     = 0;
                m_done   = 1;
                lh_tag   = m_pc;
                lh_valid = 1;
            end else begin
                m_age++;
            end
        end else begin
            m_done = 0;
            if (acc) begin
                e.pc   = pc_i;
                e.inst = fetch_word(pc_i);
                if (is_hit) begin
                    e.due  = cyc;
                    m_done = 1;
                end else begin
                    e.due = cyc + 5;
                    m_fl  = 1;
                    m_age = 0;
                    m_pc  = pc_i;
                end
                q.push_back(e);
            end
        end
        if (mem_wr_i) lh_valid = 0;
    endtask

    task automatic step(input logic r_if, input logic [31:0] r_pc, input logic r_fl,
                        input logic r_st, input logic r_wr);
        bit rd_m;
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        if_i        = r_if;
        pc_i        = r_pc;
        flush_i     = r_fl;
        mem_stall_i = r_st;
        mem_wr_i    = r_wr;
        // A flush in the DONE cycle suppresses the pulse that is due now.
        if (m_done && r_fl && q.size() > 0) void'(q.pop_front());
        #1;
        rd_m = m_fl && (m_age < 4);
        chk("if_busy", {31'd0, if_busy_o}, {31'd0, m_fl || r_st});
        chk("mem_rd", {31'd0, mem_rd_o}, {31'd0, rd_m});
        chk("mem_a", mem_a_o, rd_m ? (m_pc + 32'(m_age)) : 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst         = 1'b0;
        if_i        = 1'b0;
        pc_i        = 32'd0;
        flush_i     = 1'b0;
        mem_stall_i = 1'($urandom);
        mem_wr_i    = 1'b0;
        #1;
        chk("rst_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("rst_inst", inst_o, 32'd0);
        chk("rst_inst_pc", inst_pc_o, 32'd0);
        chk("rst_mem_rd", {31'd0, mem_rd_o}, 32'd0);
        chk("rst_mem_a", mem_a_o, 32'd0);
        chk("rst_busy", {31'd0, if_busy_o}, {31'd0, mem_stall_i});
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        mem_stall_i = 1'b0;
        rst         = 1'b1;
    endtask

    // Monitor: every pulse must match the oldest outstanding expectation, on time.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (inst_valid_o === 1'b1) begin
                if (q.size() == 0) begin
                    chk("spurious_pulse", {31'd0, inst_valid_o}, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("inst", inst_o, e.inst);
                    chk("inst_pc", inst_pc_o, e.pc);
                    chk("pulse_cycle", 32'(cyc), 32'(e.due));
                end
            end else if (q.size() > 0 && q[0].due <= cyc) begin
                chk("missed_pulse", {31'd0, inst_valid_o}, 32'd1);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        logic [31:0] rpc;
        rst = 1'b0;
        #3;
        do_reset();

        // Basic fetch at 0x100.
        step(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
        idle(7);
        chk("first_inst", inst_o, 32'h0010_0093);
        chk("first_inst_pc", inst_pc_o, 32'h100);

        // Repeat fetch (one-cycle hit when the buffer is built in).
        step(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
        idle(7);

        // Back-to-back with if_i held.
        step(1'b1, 32'h100, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b1, 32'h104, 1'b0, 1'b0, 1'b0);
        idle(7);

        // Flush in B2 of 0x200, then 0x300.
        step(1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
        idle(7);
        chk("after_flush_pc", inst_pc_o, 32'h300);

        // Stall for three cycles with a request pending.
        for (int i = 0; i < 3; i++) step(1'b1, 32'h40, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
        idle(7);

        // Address wrap.
        step(1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        idle(7);

        // Store invalidates, then 0x100 again.
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
        idle(7);

        // Reset in the middle of a fetch.
        step(1'b1, 32'h500, 1'b0, 1'b0, 1'b0);
        idle(3);
        do_reset();
        idle(8);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0:       rpc = 32'h100;
                1:       rpc = 32'h104;
                2:       rpc = 32'hFFFF_FFFE;
                default: rpc = $urandom;
            endcase
            step(1'($urandom_range(0, 2) != 0), rpc, 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 11) == 0));
        end
        idle(10);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
